// File: rtl/crop_pkg.sv
// crop_pkg: shared FSM state type and default image geometry for the crop sequencer.
package crop_pkg;
  localparam int CROP_IMG_W = 128;
  localparam int CROP_IMG_H = 128;
  localparam int CROP_PIX_W = 24;
  typedef enum logic [2:0] {IDLE, CHECK, READ, DRAIN, DONE} crop_state_e;
endpackage

// File: rtl/crop_addr_gen.sv
// crop_addr_gen: row-major raster walker over an inclusive box, yielding the source address.
module crop_addr_gen import crop_pkg::*; #(
  parameter int IMG_W  = CROP_IMG_W,
  parameter int IMG_H  = CROP_IMG_H,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [$clog2(IMG_W)-1:0] x_min_i,
  input  logic [$clog2(IMG_W)-1:0] x_max_i,
  input  logic [$clog2(IMG_H)-1:0] y_min_i,
  input  logic [$clog2(IMG_H)-1:0] y_max_i,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic                     last_o
);
  logic [$clog2(IMG_W)-1:0] col_q, col_d;
  logic [$clog2(IMG_H)-1:0] row_q, row_d;
  logic                     eol;
  assign eol = col_q == x_max_i;
  always_comb begin
    col_d = load_i ? x_min_i : step_i ? (eol ? x_min_i : col_q + 1'b1) : col_q;
    row_d = load_i ? y_min_i : (step_i && eol) ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = eol && row_q == y_max_i;
  assign addr_o = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);
endmodule

// File: rtl/crop_sequencer.sv
// crop_sequencer: copies a rectangular box of a source image into a compact destination image.
// Define CROP_CLAMP_EN to clamp oversize max bounds to the image edge instead of rejecting them.
module crop_sequencer import crop_pkg::*; #(
  parameter int IMG_W  = CROP_IMG_W,
  parameter int IMG_H  = CROP_IMG_H,
  parameter int PIX_W  = CROP_PIX_W,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [$clog2(IMG_W)-1:0] x_min,
  input  logic [$clog2(IMG_W)-1:0] x_max,
  input  logic [$clog2(IMG_H)-1:0] y_min,
  input  logic [$clog2(IMG_H)-1:0] y_max,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [PIX_W-1:0]         rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [PIX_W-1:0]         wr_data,
  output logic [$clog2(IMG_W):0]   out_w,
  output logic [$clog2(IMG_H):0]   out_h,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW:0] X_LIM = (XW+1)'(IMG_W-1);
  localparam logic [YW:0] Y_LIM = (YW+1)'(IMG_H-1);
  crop_state_e     state_q;
  logic [XW-1:0]   x_min_q, x_max_q, x_hi, col;
  logic [YW-1:0]   y_min_q, y_max_q, y_hi, row;
  logic [XW:0]     out_w_q;
  logic [YW:0]     out_h_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic            rd_en_q, wr_en_q, busy_q, done_q, err_q, bad, last, unused_ok;
`ifdef CROP_CLAMP_EN
  assign x_hi = {1'b0, x_max_q} > X_LIM ? X_LIM[XW-1:0] : x_max_q;
  assign y_hi = {1'b0, y_max_q} > Y_LIM ? Y_LIM[YW-1:0] : y_max_q;
  assign bad  = x_min_q > x_hi || y_min_q > y_hi;
`else
  assign x_hi = x_max_q;
  assign y_hi = y_max_q;
  assign bad  = x_min_q > x_max_q || y_min_q > y_max_q ||
                {1'b0, x_max_q} > X_LIM || {1'b0, y_max_q} > Y_LIM;
`endif
  crop_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_walk (
    .clk_i   (CLOCK_50),
    .rst_ni  (resetn),
    .load_i  (state_q == CHECK),
    .step_i  (state_q == READ && !last),
    .x_min_i (x_min_q),
    .x_max_i (x_hi),
    .y_min_i (y_min_q),
    .y_max_i (y_hi),
    .col_o   (col),
    .row_o   (row),
    .addr_o  (rd_addr),
    .last_o  (last)
  );
  assign unused_ok = ^{col, row};
  // Writes trail reads by one cycle, matching the read memory's latency.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= IDLE;
      {x_min_q, x_max_q, y_min_q, y_max_q} <= '0;
      out_w_q   <= '0;
      out_h_q   <= '0;
      wr_addr_q <= '0;
      {rd_en_q, wr_en_q, busy_q, done_q, err_q} <= '0;
    end else begin
      wr_en_q <= rd_en_q;
      if (wr_en_q) wr_addr_q <= wr_addr_q + 1'b1;
      case (state_q)
        IDLE, DONE: if (start) begin
          {x_min_q, x_max_q, y_min_q, y_max_q} <= {x_min, x_max, y_min, y_max};
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= CHECK;
        end
        CHECK: begin
          wr_addr_q <= '0;
          if (bad) begin
            out_w_q <= '0;
            out_h_q <= '0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            out_w_q <= {1'b0, x_hi} - {1'b0, x_min_q} + 1'b1;
            out_h_q <= {1'b0, y_hi} - {1'b0, y_min_q} + 1'b1;
            rd_en_q <= 1'b1;
            state_q <= READ;
          end
        end
        READ: if (last) begin
          rd_en_q <= 1'b0;
          state_q <= DRAIN;
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rd_en   = rd_en_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_en_q ? rd_data : '0;
  assign out_w   = out_w_q;
  assign out_h   = out_h_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_crop_sequencer.sv
// tb_crop_sequencer: directed and random crops of an 8x8 image whose pixel value equals its address.
module tb_crop_sequencer;
  logic       clk = 1'b0;
  logic       resetn, start;
  logic [2:0] x_min, x_max, y_min, y_max;
  logic       rd_en, wr_en, busy, done, err;
  logic [5:0] rd_addr, wr_addr;
  logic [7:0] rd_data, wr_data;
  logic [3:0] out_w, out_h;
  logic       rd_en2, wr_en2, busy2, done2, err2;
  logic [5:0] rd_addr2, wr_addr2;
  logic [7:0] rd_data2, wr_data2;
  logic [3:0] out_w2, out_h2;
  int checks = 0, errors = 0;
  int wa[$], wd[$];
  int wc2 = 0, ws2 = 0;

  always #5 clk = ~clk;

  crop_sequencer #(.IMG_W(8), .IMG_H(8), .PIX_W(8)) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_w(out_w), .out_h(out_h), .busy(busy), .done(done), .err(err)
  );

  // A 6-wide image lets a 3-bit x_max exceed the last column.
  crop_sequencer #(.IMG_W(6), .IMG_H(8), .PIX_W(8)) dut2 (
    .CLOCK_50(clk), .resetn(resetn), .start(start),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .out_w(out_w2), .out_h(out_h2), .busy(busy2), .done(done2), .err(err2)
  );

  always @(posedge clk) begin
    if (rd_en) rd_data <= 8'(rd_addr);
    if (rd_en2) rd_data2 <= 8'(rd_addr2);
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
    end
    if (wr_en2) begin
      wc2++;
      ws2 += int'(wr_data2);
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected image: every pixel of the box in row-major order, value = source address.
  task automatic crop(input int xa, input int xb, input int ya, input int yb, input int rep);
    int exp_d[$];
    int cnt, lat;
    bit ok;
    ok = xa <= xb && ya <= yb;
    for (int r = ya; r <= yb; r++)
      for (int c = xa; c <= xb; c++) exp_d.push_back(r * 8 + c);
    lat = ok ? exp_d.size() + 3 : 2;
    wa.delete();
    wd.delete();
    x_min = 3'(xa); x_max = 3'(xb); y_min = 3'(ya); y_max = 3'(yb);
    start = 1'b1;
    cnt = 0;
    do begin
      tick;
      cnt++;
      start = (cnt == rep);
      if (cnt == rep) {x_min, x_max, y_min, y_max} = 12'($urandom);
      if (cnt == 1) begin
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
      end
    end while (!done && cnt < 300);
    start = 1'b0;
    check("done", done, 1);
    check("latency", cnt, lat);
    check("err", err, !ok);
    check("write_count", wa.size(), exp_d.size());
    if (ok) begin
      check("out_w", out_w, xb - xa + 1);
      check("out_h", out_h, yb - ya + 1);
    end
    for (int i = 0; i < wa.size() && i < exp_d.size(); i++) begin
      check("wr_addr", wa[i], i);
      check("wr_data", wd[i], exp_d[i]);
    end
    tick;
    tick;
    check("done_held", done, 1);
    check("busy_idle", busy, 0);
    check("no_late_writes", wa.size(), exp_d.size());
  endtask

  initial begin
    int reads, cnt, nw, ew2, es2;
    resetn = 1'b0;
    start  = 1'b0;
    {x_min, x_max, y_min, y_max} = '0;
    tick;
    tick;
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_out_w", out_w, 0);
    check("rst_out_h", out_h, 0);
    check("rst_wr_addr", wr_addr, 0);
    resetn = 1'b1;
    tick;
    crop(2, 4, 1, 2, 0);
    crop(5, 5, 7, 7, 0);
    crop(6, 3, 0, 7, 0);
    crop(2, 4, 1, 2, 3);
    crop(0, 7, 0, 0, 0);
    // Reset during the third read of a full-image crop.
    x_min = 3'd0; x_max = 3'd7; y_min = 3'd0; y_max = 3'd7;
    wa.delete();
    wd.delete();
    start = 1'b1;
    reads = 0;
    cnt = 0;
    do begin
      tick;
      cnt++;
      start = 1'b0;
      if (rd_en) reads++;
    end while (reads < 3 && cnt < 50);
    check("reads_before_rst", reads, 3);
    nw = wa.size();
    check("writes_before_rst", nw, 2);
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    check("abort_wr_en", wr_en, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out_w", out_w, 0);
    repeat (4) tick;
    check("abort_no_writes", wa.size(), nw);
    crop(0, 7, 0, 7, 0);
    // Out-of-range x_max on the 6-wide instance.
    wc2 = 0;
    ws2 = 0;
    crop(4, 7, 0, 0, 0);
`ifdef CROP_CLAMP_EN
    ew2 = 2;
    es2 = 4 + 5;
    check("clamp_err", err2, 0);
    check("clamp_out_w", out_w2, 2);
`else
    ew2 = 0;
    es2 = 0;
    check("range_err", err2, 1);
`endif
    check("range_done", done2, 1);
    check("range_writes", wc2, ew2);
    check("range_data_sum", ws2, es2);
    for (int k = 0; k < 10; k++)
      crop($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
